// File: rtl/kbd_event_queue.sv
// rtl/kbd_event_queue.sv - PS/2 scan-code decoder feeding a CPU-readable key event FIFO
module kbd_event_queue #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ps2_byte,
    input  logic        ps2_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } dec_state_t;

    dec_state_t       state, state_next;
    logic [2:0]       skip_cnt, skip_next;
    logic             ps2_ready_q;
    logic             byte_edge;
    logic             push_req, push_ext, push_rel;

    logic [9:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             overflow;
    logic             empty, full;
    logic             pop_req, pop_eff, push_eff, ovf_set;
    logic             ctrl_wr, flush, clr_ovf;
    logic [9:0]       head;
    logic [31:0]      status_word;
    logic             unused_wdata;

    assign byte_edge = ps2_ready && !ps2_ready_q;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign ctrl_wr  = mem_write && (mem_addr == 8'h02);
    assign flush    = ctrl_wr && mem_wdata[0];
    assign clr_ovf  = ctrl_wr && mem_wdata[1];
    assign pop_req  = mem_read && (mem_addr == 8'h00);
    assign pop_eff  = pop_req && !empty;
    // A full FIFO still takes a new event when a pop frees a slot in the same cycle.
    assign push_eff = push_req && (!full || pop_eff);
    assign ovf_set  = push_req && full && !pop_eff && !flush;
    assign head     = fifo_mem[rd_ptr];

    assign status_word = {16'b0, {(8-CNT_W){1'b0}}, count, 5'b0, overflow, full, empty};
    assign unused_wdata = ^mem_wdata[31:2];

    // Rising-edge detector for the level-style ready flag.
    always_ff @(posedge clk) begin
        if (reset) ps2_ready_q <= 1'b0;
        else       ps2_ready_q <= ps2_ready;
    end

    // Decoder state register; a flush also abandons any partial prefix sequence.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    // Decoder next-state: prefixes only steer the state, data bytes emit one event.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        push_req   = 1'b0;
        push_ext   = 1'b0;
        push_rel   = 1'b0;
        if (byte_edge) begin
            case (state)
                IDLE: begin
                    if (ps2_byte == 8'hE0) begin
                        state_next = EXT;
                    end else if (ps2_byte == 8'hF0) begin
                        state_next = BRK;
                    end else if (ps2_byte == 8'hE1) begin
                        state_next = SKIP;
                        skip_next  = 3'd7;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2_byte == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else begin
                        push_req   = 1'b1;
                        push_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    push_req   = 1'b1;
                    push_rel   = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    push_req   = 1'b1;
                    push_ext   = 1'b1;
                    push_rel   = 1'b1;
                    state_next = IDLE;
                end
                SKIP: begin
                    // Pause key: swallow the remaining seven bytes of its sequence.
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Occupancy after this cycle's push/pop/flush, shared by count and irq.
    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push_eff && !pop_eff)
            count_next = count + CNT_W'(1);
        else if (pop_eff && !push_eff)
            count_next = count - CNT_W'(1);
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // FIFO storage; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push_eff)
            fifo_mem[wr_ptr] <= {push_ext, push_rel, ps2_byte};
    end

    // Sticky overflow; a simultaneous set beats the software clear.
    always_ff @(posedge clk) begin
        if (reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    // Interrupt tracks post-update occupancy.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= (count_next != '0);
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata <= 32'h0;
        end else if (mem_read) begin
            case (mem_addr)
                8'h00:   mem_rdata <= {!empty, 21'b0, (empty ? 10'h000 : head)};
                8'h01:   mem_rdata <= status_word;
                default: mem_rdata <= 32'h0;
            endcase
        end
    end

endmodule
